// File: rtl/pc_gen.sv
// Fetch-stage next-PC generator: trap > redirect > stall > RAS return > PC+4,
// with a small circular return-address stack fed by predicted calls.
module pc_gen #(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            call,
   input  logic            ret,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            misalign_fault,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int             PW      = $clog2(RAS_DEPTH);
   localparam int             CW      = PW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(RAS_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            misalign_q, misalign_d;
   logic [PW-1:0]   top_q, top_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];

   logic            ras_wr_en;
   logic [PW-1:0]   ras_wr_idx;
   logic [XLEN-1:0] pc_plus4;
   logic            pop_ok;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign pop_ok   = ret && (cnt_q != '0);

   always_comb begin
      pc_d       = pc_q;
      pc_valid_d = 1'b1;
      misalign_d = 1'b0;
      top_d      = top_q;
      cnt_d      = cnt_q;
      ras_wr_en  = 1'b0;
      ras_wr_idx = top_q;

      // The first cycle out of reset only raises pc_valid, so RESET_VECTOR
      // itself is presented as a valid fetch address before advancing.
      if (!pc_valid_q) begin
         pc_d = pc_q;
      end else if (trap) begin
         pc_d  = trap_vector;
         cnt_d = '0;
         top_d = '0;
      end else if (redirect) begin
         if (redirect_target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end else begin
            pc_d = redirect_target;
         end
      end else if (!stall) begin
         pc_d = pop_ok ? ras_q[top_q] : pc_plus4;
         if (call && pop_ok) begin
            // Call+return swaps the top entry in place: count is unchanged.
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_q;
         end else if (call) begin
            // Pushing onto a full stack silently overwrites the oldest entry.
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_q + 1'b1;
            top_d      = top_q + 1'b1;
            if (cnt_q != DEPTH_C) begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (pop_ok) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VECTOR;
         pc_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         top_q      <= '0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         misalign_q <= misalign_d;
         top_q      <= top_d;
         cnt_q      <= cnt_d;
      end
   end

   // Stack storage needs no reset: entries are only read while the count says they are live.
   always_ff @(posedge clk) begin
      if (!rst && ras_wr_en) begin
         ras_q[ras_wr_idx] <= pc_plus4;
      end
   end

   assign pc             = pc_q;
   assign pc_valid       = pc_valid_q;
   assign misalign_fault = misalign_q;
   assign ras_empty      = (cnt_q == '0);
   assign ras_full       = (cnt_q == DEPTH_C);

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector table for pc_gen followed by randomized traffic checked
// against a queue-based model of the fetch PC and return-address stack.
module tb_pc_gen;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        trap;
   logic [63:0] trap_vector;
   logic        redirect;
   logic [63:0] redirect_target;
   logic        call;
   logic        ret;
   logic [63:0] pc;
   logic        pc_valid;
   logic        misalign_fault;
   logic        ras_empty;
   logic        ras_full;

   int tests_run = 0;
   int tests_failed = 0;

   pc_gen #(.XLEN(64), .RESET_VECTOR(64'h0), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_vector(trap_vector),
      .redirect(redirect), .redirect_target(redirect_target), .call(call), .ret(ret),
      .pc(pc), .pc_valid(pc_valid), .misalign_fault(misalign_fault),
      .ras_empty(ras_empty), .ras_full(ras_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst, stall, trap, redirect, call, ret;
      logic [63:0] tv, rt;
      logic [63:0] e_pc;
      logic        e_valid, e_fault, e_empty, e_full;
   } vec_t;

   vec_t vecs[$];

   // Reference model: architectural PC plus the return stack as a plain queue
   // (back = most recent call).
   logic [63:0] m_pc;
   logic        m_valid;
   logic        m_fault;
   logic [63:0] m_ras[$];

   task automatic model_step();
      logic [63:0] nxt;
      m_fault = 1'b0;
      if (rst) begin
         m_pc = 64'h0; m_valid = 1'b0; m_ras.delete();
      end else if (!m_valid) begin
         m_valid = 1'b1;
      end else if (trap) begin
         m_pc = trap_vector; m_ras.delete();
      end else if (redirect) begin
         if (redirect_target[1:0] != 2'b00) m_fault = 1'b1;
         else m_pc = redirect_target;
      end else if (!stall) begin
         nxt = m_pc + 64'd4;
         if (ret && m_ras.size() > 0) nxt = m_ras.pop_back();
         if (call) m_ras.push_back(m_pc + 64'd4);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         m_pc = nxt;
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic t, input logic rd,
                        input logic c, input logic rt_, input logic [63:0] tv,
                        input logic [63:0] tgt);
      rst = r; stall = s; trap = t; redirect = rd; call = c; ret = rt_;
      trap_vector = tv; redirect_target = tgt;
   endtask

   task automatic check(input string name, input logic [63:0] e_pc, input logic e_valid,
                        input logic e_fault, input logic e_empty, input logic e_full);
      tests_run++;
      if (pc !== e_pc || pc_valid !== e_valid || misalign_fault !== e_fault ||
          ras_empty !== e_empty || ras_full !== e_full) begin
         tests_failed++;
         $display("FAIL %s: got pc=%h valid=%b fault=%b empty=%b full=%b, want pc=%h valid=%b fault=%b empty=%b full=%b",
                  name, pc, pc_valid, misalign_fault, ras_empty, ras_full,
                  e_pc, e_valid, e_fault, e_empty, e_full);
      end
   endtask

   task automatic add(input string n, input logic r, input logic s, input logic t,
                      input logic rd, input logic c, input logic rt_,
                      input logic [63:0] tv, input logic [63:0] tgt,
                      input logic [63:0] e_pc, input logic e_v, input logic e_f,
                      input logic e_e, input logic e_fu);
      vec_t v;
      v.name = n; v.rst = r; v.stall = s; v.trap = t; v.redirect = rd; v.call = c; v.ret = rt_;
      v.tv = tv; v.rt = tgt; v.e_pc = e_pc; v.e_valid = e_v; v.e_fault = e_f;
      v.e_empty = e_e; v.e_full = e_fu;
      vecs.push_back(v);
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      if ($urandom_range(3) == 0) a = {32'hFFFF_FFFF, 32'($urandom)};
      else a = {32'h0, 32'($urandom_range(0, 4095))};
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      //   name        rst s t rd c r  trap_vec   redir_tgt              pc                    v f e fu
      add("reset0",    1, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h0,                0,0,1,0);
      add("reset1",    1, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h0,                0,0,1,0);
      add("valid",     0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h0,                1,0,1,0);
      add("seq4",      0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h4,                1,0,1,0);
      add("seq8",      0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h8,                1,0,1,0);
      add("seq12",     0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'hC,                1,0,1,0);
      add("prio_trap", 0, 1,1,1, 0,0, 64'h800,   64'h100,               64'h800,              1,0,1,0);
      add("redir",     0, 0,0,1, 0,0, 64'h0,     64'h100,               64'h100,              1,0,1,0);
      add("to_40",     0, 0,0,1, 0,0, 64'h0,     64'h40,                64'h40,               1,0,1,0);
      add("misalign",  0, 0,0,1, 1,1, 64'h0,     64'h102,               64'h40,               1,1,1,0);
      add("fault_clr", 0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h44,               1,0,1,0);
      add("to_10",     0, 0,0,1, 0,0, 64'h0,     64'h10,                64'h10,               1,0,1,0);
      add("call10",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h14,               1,0,0,0);
      add("gap1",      0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h18,               1,0,0,0);
      add("gap2",      0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h1C,               1,0,0,0);
      add("ret14",     0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'h14,               1,0,1,0);
      add("ret_empty", 0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'h18,               1,0,1,0);
      add("trap0",     0, 0,1,0, 0,0, 64'h0,     64'h0,                 64'h0,                1,0,1,0);
      add("call_a",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h4,                1,0,0,0);
      add("call_b",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h8,                1,0,0,0);
      add("call_c",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'hC,                1,0,0,0);
      add("call_d",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h10,               1,0,0,1);
      add("call_ovf",  0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h14,               1,0,0,1);
      add("ret_a",     0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'h14,               1,0,0,0);
      add("ret_b",     0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'h10,               1,0,0,0);
      add("ret_c",     0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'hC,                1,0,0,0);
      add("ret_d",     0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'h8,                1,0,1,0);
      add("ret_ovf",   0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'hC,                1,0,1,0);
      add("to_top",    0, 0,0,1, 0,0, 64'h0,     64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1,0,1,0);
      add("wrap",      0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h0,                1,0,1,0);
      add("call_w",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h4,                1,0,0,0);
      add("stall_c",   0, 1,0,0, 1,0, 64'h0,     64'h0,                 64'h4,                1,0,0,0);
      add("ret_one",   0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'h4,                1,0,1,0);
      add("call_x",    0, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h8,                1,0,0,0);
      add("stall_r",   0, 1,0,0, 0,1, 64'h0,     64'h0,                 64'h8,                1,0,0,0);
      add("swap",      0, 0,0,0, 1,1, 64'h0,     64'h0,                 64'h8,                1,0,0,0);
      add("ret_swap",  0, 0,0,0, 0,1, 64'h0,     64'h0,                 64'hC,                1,0,1,0);
      add("cr_empty",  0, 0,0,0, 1,1, 64'h0,     64'h0,                 64'h10,               1,0,0,0);
      add("mid_rst",   1, 0,0,0, 1,0, 64'h0,     64'h0,                 64'h0,                0,0,1,0);
      add("valid2",    0, 0,0,0, 0,0, 64'h0,     64'h0,                 64'h0,                1,0,1,0);

      m_pc = 64'h0; m_valid = 1'b0; m_fault = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 64'h0, 64'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].trap, vecs[i].redirect,
               vecs[i].call, vecs[i].ret, vecs[i].tv, vecs[i].rt);
         @(posedge clk);
         #1;
         model_step();
         check(vecs[i].name, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_fault,
               vecs[i].e_empty, vecs[i].e_full);
         $display("[TB] vec %0d %s pc=%h valid=%b fault=%b empty=%b full=%b",
                  i, vecs[i].name, pc, pc_valid, misalign_fault, ras_empty, ras_full);
      end

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(99) == 0, $urandom_range(4) == 0, $urandom_range(31) == 0,
               $urandom_range(11) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
               rand_addr(), rand_addr());
         @(posedge clk);
         #1;
         model_step();
         check("random", m_pc, m_valid, m_fault, m_ras.size() == 0, m_ras.size() == DEPTH);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
